regfile_mp: RTL and testbench



---
 rtl/regfile_mp.sv | 149 ++++++++++++++
 tb/tb_regfile_mp.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with per-port hold, write bypass and clear sequencer; state on falling clk edge.
// Optional pending-bit scoreboard enabled by defining REGFILE_SCOREBOARD_EN.
module regfile_mp #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  output logic                busy,
  input  logic [NRD-1:0]      re,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                pset,
  input  logic [AW-1:0]       paddr,
  output logic [NRD-1:0]      pend
`endif
);

  typedef enum logic {IDLE, CLEAR} state_e;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] rd_q  [NRD];
  logic [XLEN-1:0] rd_d  [NRD];
  logic [AW-1:0]   ra_a  [NRD];
  logic [NRD-1:0]  ra_ok;
  logic            wa_ok;
  logic            wr_en;

  always_comb begin
    for (int unsigned i = 0; i < NRD; i++) begin
      ra_a[i]  = ra[i*AW +: AW];
      ra_ok[i] = (ra_a[i] != '0) && ({1'b0, ra_a[i]} < DEPTH_W);
    end
  end

  // A write on the edge that accepts clr is dropped.
  assign wa_ok = (wa != '0) && ({1'b0, wa} < DEPTH_W);
  assign wr_en = we && wa_ok && (state_q == IDLE) && !clr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (clr && (DEPTH > 1)) begin
          state_d = CLEAR;
          cnt_d   = AW'(1);
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < NRD; i++) begin
      rd_d[i] = rd_q[i];
      if (re[i]) begin
        if (!ra_ok[i] || (state_q == CLEAR)) rd_d[i] = '0;
        else if (wr_en && (wa == ra_a[i]))   rd_d[i] = wd;
        else                                 rd_d[i] = mem_q[ra_a[i]];
      end
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      for (int unsigned i = 0; i < NRD; i++)   rd_q[i]  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      if (wr_en)            mem_q[wa]    <= wd;
      if (state_q == CLEAR) mem_q[cnt_q] <= '0;
      for (int unsigned i = 0; i < NRD; i++) rd_q[i] <= rd_d[i];
    end
  end

  assign busy = busy_q;

  always_comb begin
    rd = '0;
    for (int unsigned i = 0; i < NRD; i++) rd[i*XLEN +: XLEN] = rd_q[i];
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] pv_q, pv_d;
  logic [NRD-1:0]   pend_q, pend_d;

  // Set is applied after clear so a same-entry set/clear leaves the bit set.
  always_comb begin
    pv_d = pv_q;
    if ((state_q == CLEAR) && (cnt_q == AW'(1))) begin
      pv_d = '0;
    end else begin
      if (wr_en) pv_d[wa] = 1'b0;
      if (pset && (paddr != '0) && ({1'b0, paddr} < DEPTH_W)) pv_d[paddr] = 1'b1;
    end
    for (int unsigned i = 0; i < NRD; i++) begin
      pend_d[i] = pend_q[i];
      if (re[i]) begin
        if (!ra_ok[i] || (wr_en && (wa == ra_a[i]))) pend_d[i] = 1'b0;
        else                                         pend_d[i] = pv_q[ra_a[i]];
      end
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q   <= '0;
      pend_q <= '0;
    end else begin
      pv_q   <= pv_d;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk;
  logic                rst_n;
  logic                clr;
  logic                busy;
  logic [NRD-1:0]      re;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
`ifdef REGFILE_SCOREBOARD_EN
  logic                pset;
  logic [AW-1:0]       paddr;
  logic [NRD-1:0]      pend;
`endif

  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
    .re(re), .ra(ra), .rd(rd), .we(we), .wa(wa), .wd(wd)
`ifdef REGFILE_SCOREBOARD_EN
    , .pset(pset), .paddr(paddr), .pend(pend)
`endif
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [XLEN-1:0] m_reg [DEPTH];
  logic [XLEN-1:0] m_rd  [NRD];
  int              m_left;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_reg[i] = '0;
    for (int p = 0; p < NRD; p++) m_rd[p] = '0;
    m_left = 0;
  endfunction

  // Clearing is modelled as an instant wipe plus a countdown of busy edges.
  function automatic void model_edge();
    bit clearing;
    bit legal;
    int w;
    int a;
    clearing = (m_left != 0);
    w = int'(wa);
    legal = we && (w != 0) && !clearing && !clr;
    for (int p = 0; p < NRD; p++) begin
      if (re[p]) begin
        a = int'(ra[p*AW +: AW]);
        if (a == 0 || clearing)   m_rd[p] = '0;
        else if (legal && w == a) m_rd[p] = wd;
        else                      m_rd[p] = m_reg[a];
      end
    end
    if (legal) m_reg[w] = wd;
    if (clearing) m_left = m_left - 1;
    else if (clr) begin
      m_left = DEPTH - 1;
      for (int i = 0; i < DEPTH; i++) m_reg[i] = '0;
    end
  endfunction

  task automatic step();
    model_edge();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic set_ra(input int a1, input int a0);
    logic [AW-1:0] x1;
    logic [AW-1:0] x0;
    x1 = a1[AW-1:0];
    x0 = a0[AW-1:0];
    ra = {x1, x0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 0; we = 0; wa = '0; wd = '0; re = '0; ra = '0;
`ifdef REGFILE_SCOREBOARD_EN
    pset = 0; paddr = '0;
`endif
    model_reset();
    @(posedge clk);
    n_total++;
    if (rd !== '0 || busy !== 1'b0) $display("FAIL reset_state: rd=%h busy=%b expected rd=0 busy=0", rd, busy);
    else n_pass++;
    rst_n = 1'b1;
    re = 2'b11; set_ra(0, 5);
    step();
    n_total++;
    if (rd !== '0 || busy !== 1'b0) $display("FAIL reset_read: rd=%h busy=%b expected rd=0 busy=0", rd, busy);
    else n_pass++;
  endtask

  task automatic test_write_read();
    re = 2'b00; we = 1; wa = 5'd7; wd = 32'hDEADBEEF;
    step();
    we = 0; re = 2'b01; set_ra(0, 7);
    step();
    n_total++;
    if (rd[31:0] !== 32'hDEADBEEF) $display("FAIL write_read: rd0=%h expected deadbeef", rd[31:0]);
    else n_pass++;
  endtask

  task automatic test_bypass();
    we = 1; wa = 5'd3; wd = 32'h1234; re = 2'b10; set_ra(3, 0);
    step();
    we = 0;
    n_total++;
    if (rd[63:32] !== 32'h1234) $display("FAIL bypass: rd1=%h expected 00001234", rd[63:32]);
    else n_pass++;
  endtask

  task automatic test_zero_and_hold();
    we = 1; wa = '0; wd = 32'hFFFF_FFFF; re = 2'b00;
    step();
    we = 0; re = 2'b11; set_ra(0, 0);
    step();
    n_total++;
    if (rd !== '0) $display("FAIL zero_reg: rd=%h expected 0", rd);
    else n_pass++;
    re = 2'b01; set_ra(0, 7);
    step();
    re = 2'b10; set_ra(3, 3);
    step();
    n_total++;
    if (rd[31:0] !== 32'hDEADBEEF || rd[63:32] !== 32'h1234)
      $display("FAIL hold: rd=%h expected 00001234deadbeef", rd);
    else n_pass++;
  endtask

  task automatic fill_all();
    re = 2'b00;
    for (int a = 1; a < DEPTH; a++) begin
      we = 1; wa = a[AW-1:0]; wd = $urandom | 32'h1;
      step();
    end
    we = 0;
  endtask

  task automatic test_clear();
    int edges;
    fill_all();
    clr = 1;
    step();
    clr = 0;
    edges = 0;
    while (busy === 1'b1 && edges < 100) begin
      edges++;
      if (edges == 5) begin we = 1; wa = 5'd9; wd = 32'hA5A5_A5A5; end
      else we = 0;
      step();
    end
    we = 0;
    n_total++;
    if (edges !== DEPTH - 1) $display("FAIL clear_busy_len: edges=%0d expected %0d", edges, DEPTH - 1);
    else n_pass++;
    re = 2'b11;
    for (int a = 0; a < DEPTH; a += 2) begin
      set_ra(a + 1, a);
      step();
      n_total++;
      if (rd !== '0) $display("FAIL clear_read a=%0d: rd=%h expected 0", a, rd);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_clear();
    fill_all();
    clr = 1;
    step();
    clr = 0;
    for (int i = 0; i < 9; i++) step();
    n_total++;
    if (busy !== 1'b1) $display("FAIL busy_before_abort: busy=%b expected 1", busy);
    else n_pass++;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (busy !== 1'b0 || rd !== '0) $display("FAIL async_reset: busy=%b rd=%h expected 0", busy, rd);
    else n_pass++;
    @(posedge clk);
    rst_n = 1'b1;
    re = 2'b11;
    for (int a = 0; a < DEPTH; a += 2) begin
      set_ra(a + 1, a);
      step();
      n_total++;
      if (rd !== '0 || busy !== 1'b0) $display("FAIL abort_read a=%0d: rd=%h busy=%b expected 0", a, rd, busy);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      clr = ($urandom_range(0, 63) == 0);
      we  = $urandom_range(0, 1);
      wa  = $urandom_range(0, DEPTH - 1);
      wd  = $urandom;
      re  = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) set_ra(int'(wa), $urandom_range(0, DEPTH - 1));
      else set_ra($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
      step();
      for (int p = 0; p < NRD; p++) begin
        n_total++;
        if (rd[p*XLEN +: XLEN] !== m_rd[p])
          $display("FAIL random_rd%0d cycle %0d: got %h expected %h", p, c, rd[p*XLEN +: XLEN], m_rd[p]);
        else n_pass++;
      end
      n_total++;
      if (busy !== (m_left != 0)) $display("FAIL random_busy cycle %0d: got %b expected %b", c, busy, m_left != 0);
      else n_pass++;
    end
    clr = 0; we = 0;
    while (m_left != 0) step();
  endtask

`ifdef REGFILE_SCOREBOARD_EN
  task automatic test_pending();
    re = 2'b00; pset = 1; paddr = 5'd4;
    step();
    pset = 0; re = 2'b01; set_ra(0, 4);
    step();
    n_total++;
    if (pend[0] !== 1'b1) $display("FAIL pend_set: pend0=%b expected 1", pend[0]);
    else n_pass++;
    re = 2'b00; we = 1; wa = 5'd4; wd = 32'h4444;
    step();
    we = 0; re = 2'b01;
    step();
    n_total++;
    if (pend[0] !== 1'b0 || rd[31:0] !== 32'h4444) $display("FAIL pend_clr: pend0=%b rd0=%h expected 0 00004444", pend[0], rd[31:0]);
    else n_pass++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_and_hold();
    test_clear();
    test_reset_mid_clear();
    test_random();
`ifdef REGFILE_SCOREBOARD_EN
    test_pending();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
